// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_ctrl_pkg                                            |
// | Brief   : Op codes, FSM states and decode helpers shared by the      |
// |           multiply/divide sequencer and the ID-stage decoder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_CALC  = 2'd2,
        S_FIXUP = 2'd3
    } md_state_t;

    // Multiply or divide: starts an iterative operation.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // Any op that touches HI/LO and therefore must wait for the unit.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_ctrl_if                                             |
// | Brief   : EX-stage <-> multiply/divide unit bundle. The pipeline is  |
// |           the master (issues ops), the unit is the slave.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op_ex;
    logic [WIDTH-1:0] rs_data_ex;
    logic [WIDTH-1:0] rt_data_ex;
    logic             stall_ex;
    logic [WIDTH-1:0] mf_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output op_ex, rs_data_ex, rt_data_ex,
        input  stall_ex, mf_result, hi, lo, busy, done
    );

    modport slave (
        input  op_ex, rs_data_ex, rt_data_ex,
        output stall_ex, mf_result, hi, lo, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_ctrl_iter                                           |
// | Brief   : Unsigned iterative datapath. Shift-add multiply or         |
// |           restoring divide, one bit per i_step. After WIDTH steps    |
// |           {o_hi,o_lo} is the product, or o_hi=remainder,            |
// |           o_lo=quotient.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_ctrl_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;

    // Next-step arithmetic; the top bit of w_div_diff is the borrow of the trial subtract.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
    end

    // Accumulator (r_hi) and multiplier/quotient (r_lo) shift registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            if (i_is_div) begin
                r_hi <= w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
            end else begin
                r_hi <= w_mul_sum[WIDTH:1];
                r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_ctrl                                                |
// | Brief   : MIPS HI/LO multiply/divide sequencer. Fixed WIDTH+2 cycle  |
// |           MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, combinational |
// |           MFHI/MFLO and the EX-stage stall.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    md_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Magnitudes handed to the unsigned datapath during PREP.
    always_comb begin
        w_abs_a = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
        w_abs_b = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    end

    muldiv_ctrl_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (r_state == S_PREP),
        .i_step   (r_state == S_CALC),
        .i_is_div (r_is_div),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_it_hi),
        .o_lo     (w_it_lo)
    );

    // Sign restoration of the unsigned result; divide-by-zero returns the dividend untouched.
    always_comb begin
        w_prod   = {w_it_hi, w_it_lo};
        w_fix_hi = '0;
        w_fix_lo = '0;
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_hi = r_a;
                w_fix_lo = DIV0_LO;
            end else begin
                w_fix_hi = r_neg_r ? -w_it_hi : w_it_hi;
                w_fix_lo = r_neg_q ? -w_it_lo : w_it_lo;
            end
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Sequencer FSM, operand latches and the architectural HI/LO pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (is_md_op(bus.op_ex)) begin
                        r_a      <= bus.rs_data_ex;
                        r_b      <= bus.rt_data_ex;
                        r_signed <= is_signed_op(bus.op_ex);
                        r_is_div <= is_div_op(bus.op_ex);
                        r_state  <= S_PREP;
                    end else if (bus.op_ex == MD_MTHI) begin
                        r_hi <= bus.rs_data_ex;
                    end else if (bus.op_ex == MD_MTLO) begin
                        r_lo <= bus.rs_data_ex;
                    end
                end
                S_PREP: begin
                    r_neg_q <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= r_signed && r_a[WIDTH-1];
                    r_div0  <= (r_b == '0);
                    r_cnt   <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_ex  = is_hilo_op(bus.op_ex) && (r_state != S_IDLE);
    assign bus.mf_result = (bus.op_ex == MD_MFHI) ? r_hi :
                           (bus.op_ex == MD_MFLO) ? r_lo : '0;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_muldiv_ctrl                                             |
// | Brief   : Self-checking bench for muldiv_ctrl: directed cases plus   |
// |           random MD ops against an arithmetic reference model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int          W       = 32;
    localparam logic [31:0] DIV0    = 32'hFFFFFFFF;
    localparam int          LATENCY = W + 2;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(
        .WIDTH   (W),
        .DIV0_LO (DIV0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: {hi, lo} for an MD op.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) return {a, DIV0};
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, DIV0};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the done pulse, sampling after each rising edge; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.done !== 1'b1 && n < 3 * LATENCY);
    endtask

    // Issue one MD op from IDLE, check accept, latency, result and the single-cycle done.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] e;
        int          n;
        e = ref_md(op, a, b);
        @(negedge clk);
        bus.op_ex = op; bus.rs_data_ex = a; bus.rt_data_ex = b;
        #1;
        chk({tag, "_accept_stall"}, 64'(bus.stall_ex), 64'd0);
        @(posedge clk); #1;
        bus.op_ex = MD_NONE;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(n);
        chk({tag, "_latency"}, 64'(n), 64'(LATENCY));
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, e);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          n;
        logic [63:0] e1;
        logic [63:0] e2;
        reset = 1'b0;
        bus.op_ex = MD_NONE; bus.rs_data_ex = '0; bus.rt_data_ex = '0;
        #1;
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_stall", 64'(bus.stall_ex), 64'd0);
        @(negedge clk); reset = 1'b1;

        run_md("mult_neg1x2", MD_MULT, 32'hFFFFFFFF, 32'h00000002);
        run_md("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md("divu_7_2", MD_DIVU, 32'd7, 32'd2);
        run_md("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2);
        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("div_by0", MD_DIV, 32'h00001234, 32'h0);
        run_md("divu_by0", MD_DIVU, 32'h89ABCDEF, 32'h0);
        run_md("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE);

        // MULT followed by MFLO: stalls every non-IDLE cycle, then reads the new LO.
        @(negedge clk);
        bus.op_ex = MD_MULT; bus.rs_data_ex = 32'd3; bus.rt_data_ex = 32'd5;
        @(negedge clk);
        bus.op_ex = MD_MFLO;
        n = 0;
        #1;
        while (bus.stall_ex === 1'b1 && n < 3 * LATENCY) begin
            n++;
            @(negedge clk); #1;
        end
        chk("mflo_stall_cycles", 64'(n), 64'(LATENCY));
        chk("mflo_result", 64'(bus.mf_result), 64'h0000000F);
        bus.op_ex = MD_MFHI;
        #1;
        chk("mfhi_result", 64'(bus.mf_result), 64'h0);
        chk("mfhi_stall", 64'(bus.stall_ex), 64'd0);
        bus.op_ex = 4'd12;
        #1;
        chk("op12_mf_zero", 64'(bus.mf_result), 64'h0);
        chk("op12_stall", 64'(bus.stall_ex), 64'd0);
        @(posedge clk); #1;
        chk("op12_not_busy", 64'(bus.busy), 64'd0);
        bus.op_ex = MD_NONE;

        // MTHI presented while busy: stalled, in-flight product intact, then applied.
        @(negedge clk);
        bus.op_ex = MD_MULT; bus.rs_data_ex = 32'h00010000; bus.rt_data_ex = 32'h00010000;
        @(negedge clk);
        bus.op_ex = MD_MTHI; bus.rs_data_ex = 32'h0000DEAD;
        #1;
        chk("mt_busy_stall", 64'(bus.stall_ex), 64'd1);
        wait_done(n);
        chk("mt_busy_hilo", {bus.hi, bus.lo}, 64'h00000001_00000000);
        chk("mt_busy_unstall", 64'(bus.stall_ex), 64'd0);
        @(posedge clk); #1;
        chk("mt_after_hi", 64'(bus.hi), 64'h0000DEAD);
        bus.op_ex = MD_MTLO; bus.rs_data_ex = 32'h00000055;
        @(posedge clk); #1;
        chk("mtlo_lo", 64'(bus.lo), 64'h00000055);
        bus.op_ex = MD_NONE;

        // Back-to-back MD ops: the stalled second op starts on the first IDLE cycle.
        e1 = ref_md(MD_MULTU, 32'h12345678, 32'h9ABCDEF0);
        e2 = ref_md(MD_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        bus.op_ex = MD_MULTU; bus.rs_data_ex = 32'h12345678; bus.rt_data_ex = 32'h9ABCDEF0;
        @(negedge clk);
        bus.op_ex = MD_DIVU; bus.rs_data_ex = 32'd100; bus.rt_data_ex = 32'd7;
        wait_done(n);
        chk("b2b_first", {bus.hi, bus.lo}, e1);
        @(posedge clk); #1;
        bus.op_ex = MD_NONE;
        chk("b2b_second_busy", 64'(bus.busy), 64'd1);
        wait_done(n);
        chk("b2b_second_lat", 64'(n), 64'(LATENCY));
        chk("b2b_second", {bus.hi, bus.lo}, e2);

        // Asynchronous reset in the middle of CALC abandons the divide.
        @(negedge clk);
        bus.op_ex = MD_DIV; bus.rs_data_ex = 32'hFFFFFF9C; bus.rt_data_ex = 32'd3;
        @(posedge clk); #1;
        bus.op_ex = MD_NONE;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.op_ex = MD_MTHI; bus.rs_data_ex = 32'h000000A5;
        @(posedge clk); #1;
        chk("rst_mthi", {bus.hi, bus.lo}, 64'h000000A5_00000000);
        bus.op_ex = MD_NONE;

        // Randomized MD ops against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(1, 4));
            a  = pick();
            b  = pick();
            run_md($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
